// File: rtl/posit_decoder_pipe_if.sv
// Stream interface between a posit word source and the posit decoder pipeline.
// The master supplies posit words and consumes decoded fields; the slave is the decoder.
interface posit_decoder_pipe_if #(
    parameter int N  = 16,
    parameter int ES = 1
);
    localparam int K_W  = $clog2(N) + 1;
    localparam int FL_W = $clog2(N);
    localparam int EW   = (ES > 0) ? ES : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0]           posit;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sign;
    logic signed [K_W-1:0]  k;
    logic [EW-1:0]          exp;
    logic [N-1:0]           frac;
    logic [FL_W-1:0]        frac_len;
    logic                   is_zero;
    logic                   is_nar;

    modport master (
        output in_valid, posit, out_ready,
        input  in_ready, out_valid, sign, k, exp, frac, frac_len, is_zero, is_nar
    );

    modport slave (
        input  in_valid, posit, out_ready,
        output in_ready, out_valid, sign, k, exp, frac, frac_len, is_zero, is_nar
    );
endinterface

// File: rtl/posit_decoder_pipe.sv
// Two-stage posit decoder: stage 1 captures sign/magnitude and special flags,
// stage 2 extracts regime, exponent and right-aligned fraction.
module posit_decoder_pipe #(
    parameter int N  = 16,
    parameter int ES = 1
) (
    input  logic               clk,
    input  logic               rst,
    posit_decoder_pipe_if.slave bus
);
    localparam int K_W  = $clog2(N) + 1;
    localparam int FL_W = $clog2(N);
    localparam int EW   = (ES > 0) ? ES : 1;

    logic                  s1_valid;
    logic                  s2_valid;
    logic                  s1_adv;
    logic                  sign_p1;
    logic                  zero_p1;
    logic                  nar_p1;
    logic [N-1:0]          mag_p1;

    logic                  r0;
    logic                  run;
    int                    m;
    int                    reg_len;
    int                    rem;
    int                    fl;
    logic signed [K_W-1:0] k_d;
    logic [EW-1:0]         exp_d;
    logic [N-1:0]          frac_d;
    logic [FL_W-1:0]       fl_d;

    assign s1_adv        = !s2_valid || bus.out_ready;
    assign bus.in_ready  = !s1_valid || s1_adv;
    assign bus.out_valid = s2_valid;

    // Stage 1: capture sign, two's-complement magnitude and special-value flags
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            sign_p1 <= bus.posit[N-1];
            mag_p1  <= bus.posit[N-1] ? -bus.posit : bus.posit;
            zero_p1 <= (bus.posit == '0);
            nar_p1  <= (bus.posit == {1'b1, {(N-1){1'b0}}});
        end
    end

    // Field extraction from the magnitude below its sign position
    always_comb begin
        r0  = mag_p1[N-2];
        run = 1'b1;
        m   = 0;
        for (int i = N - 2; i >= 0; i--) begin
            if (run && (mag_p1[i] == r0)) m = m + 1;
            else                          run = 1'b0;
        end
        k_d     = r0 ? K_W'(m - 1) : K_W'(-m);
        // A run that reaches the LSB has no terminator bit
        reg_len = (m + 1 < N - 1) ? m + 1 : N - 1;
        rem     = N - 1 - reg_len;
        exp_d   = '0;
        for (int j = 0; j < ES; j++) begin
            if (j < rem) exp_d[ES-1-j] = mag_p1[rem-1-j];
        end
        fl     = (rem > ES) ? rem - ES : 0;
        frac_d = '0;
        for (int i = 0; i < N; i++) begin
            if (i < fl) frac_d[i] = mag_p1[i];
        end
        fl_d = FL_W'(fl);
        if (zero_p1 || nar_p1) begin
            k_d    = '0;
            exp_d  = '0;
            frac_d = '0;
            fl_d   = '0;
        end
    end

    // Stage 2: output registers, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            bus.sign     <= 1'b0;
            bus.k        <= '0;
            bus.exp      <= '0;
            bus.frac     <= '0;
            bus.frac_len <= '0;
            bus.is_zero  <= 1'b0;
            bus.is_nar   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.sign     <= sign_p1;
                bus.k        <= k_d;
                bus.exp      <= exp_d;
                bus.frac     <= frac_d;
                bus.frac_len <= fl_d;
                bus.is_zero  <= zero_p1;
                bus.is_nar   <= nar_p1;
            end
        end
    end
endmodule

// File: tb/tb_posit_decoder_pipe.sv
// Bench for posit_decoder_pipe: directed posit values, randomized streaming with
// backpressure against an arithmetic posit reference model, and reset flush.
module tb_posit_decoder_pipe;
    localparam int N    = 16;
    localparam int ES   = 1;
    localparam int K_W  = $clog2(N) + 1;
    localparam int FL_W = $clog2(N);
    localparam int EW   = (ES > 0) ? ES : 1;
    localparam int PW   = 1 + K_W + EW + N + FL_W + 2;

    logic clk = 1'b0;
    logic rst;

    posit_decoder_pipe_if #(.N(N), .ES(ES)) bus ();

    posit_decoder_pipe #(.N(N), .ES(ES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int count    = 0;
    int cyc      = 0;
    bit lat_on   = 1'b0;
    logic [PW-1:0] exp_in;
    logic [PW-1:0] q[$];
    int            tq[$];

    logic [PW-1:0] dut_pk;
    assign dut_pk = {bus.sign, bus.k, bus.exp, bus.frac, bus.frac_len, bus.is_zero, bus.is_nar};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic logic [PW-1:0] pk(int s, int kk, int e, int f, int fl, int z, int n);
        logic sb, zb, nb;
        sb = (s != 0);
        zb = (z != 0);
        nb = (n != 0);
        return {sb, K_W'(kk), EW'(e), N'(f), FL_W'(fl), zb, nb};
    endfunction

    function automatic int bitlen(int y);
        int b = 0;
        while ((y >> b) != 0) b++;
        return b;
    endfunction

    // Reference: regime length from the bit length of the body (or of its complement)
    function automatic logic [PW-1:0] model(logic [N-1:0] p);
        int s, mag, x, body_max, m, kk, rl, rem, low, ebits, fl, e, f;
        if (p == 0) return pk(0, 0, 0, 0, 0, 1, 0);
        if (p == (1 << (N - 1))) return pk(1, 0, 0, 0, 0, 0, 1);
        s        = p[N-1];
        mag      = s ? ((1 << N) - int'(p)) % (1 << N) : int'(p);
        body_max = (1 << (N - 1)) - 1;
        x        = mag % (1 << (N - 1));
        if (x >= (1 << (N - 2))) begin
            m  = (N - 1) - bitlen(body_max - x);
            kk = m - 1;
        end else begin
            m  = (N - 1) - bitlen(x);
            kk = -m;
        end
        rl    = (m + 1 < N - 1) ? m + 1 : N - 1;
        rem   = N - 1 - rl;
        low   = x % (1 << rem);
        ebits = (ES < rem) ? ES : rem;
        fl    = (rem - ES > 0) ? rem - ES : 0;
        e     = (low >> fl) << (ES - ebits);
        f     = low % (1 << fl);
        return pk(s, kk, e, f, fl, 0, 0);
    endfunction

    task automatic step();
        logic acc, emt;
        logic [PW-1:0] want;
        int t0;
        @(negedge clk);
        check("in_ready", 64'(bus.in_ready), 64'(!(count == 2 && !bus.out_ready)));
        acc = bus.in_valid && bus.in_ready;
        emt = bus.out_valid && bus.out_ready;
        if (emt) begin
            if (q.size() == 0) begin
                check("spurious_out", 64'(bus.out_valid), 64'(0));
            end else begin
                want = q.pop_front();
                t0   = tq.pop_front();
                check("fields", 64'(dut_pk), 64'(want));
                if (lat_on) check("latency", 64'(cyc - t0), 64'(2));
            end
        end
        if (acc) begin
            q.push_back(exp_in);
            tq.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        count = count + int'(acc) - int'(emt);
        #1;
    endtask

    logic [N-1:0]  dir_w[10] = '{16'h4000, 16'h5A00, 16'hC000, 16'h0000, 16'h8000,
                                 16'h7FFF, 16'h0001, 16'h0800, 16'h7000, 16'hFFFF};
    logic [PW-1:0] dir_e[10];

    initial begin
        dir_e[0] = pk(0,   0, 0, 0,     12, 0, 0);
        dir_e[1] = pk(0,   0, 1, 'hA00, 12, 0, 0);
        dir_e[2] = pk(1,   0, 0, 0,     12, 0, 0);
        dir_e[3] = pk(0,   0, 0, 0,     0,  1, 0);
        dir_e[4] = pk(1,   0, 0, 0,     0,  0, 1);
        dir_e[5] = pk(0,  14, 0, 0,     0,  0, 0);
        dir_e[6] = pk(0, -14, 0, 0,     0,  0, 0);
        dir_e[7] = pk(0,  -3, 0, 0,     10, 0, 0);
        dir_e[8] = pk(0,   2, 0, 0,     10, 0, 0);
        dir_e[9] = pk(1, -14, 0, 0,     0,  0, 0);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.posit     = '0;
        bus.out_ready = 1'b0;
        exp_in        = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  64'(bus.in_ready),  64'(1));
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_fields",    64'(dut_pk),        64'(0));
        @(posedge clk);
        #1;

        // Directed values, back-to-back with the consumer always ready
        lat_on        = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.posit    = dir_w[i];
            exp_in       = dir_e[i];
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        check("directed_drained", 64'(q.size()), 64'(0));
        lat_on = 1'b0;

        // Randomized streaming with random backpressure
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.posit     = N'($urandom);
            bus.out_ready = $urandom_range(1);
            exp_in        = model(bus.posit);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        check("random_drained", 64'(q.size()), 64'(0));

        // Fill the pipe under stall, then reset with both words in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.posit    = 16'h4000 + N'(i);
            exp_in       = model(bus.posit);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check("full_count", 64'(count), 64'(2));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        tq.delete();
        count = 0;
        @(negedge clk);
        check("flush_out_valid", 64'(bus.out_valid), 64'(0));
        check("flush_in_ready",  64'(bus.in_ready),  64'(1));
        check("flush_fields",    64'(dut_pk),        64'(0));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/posit_decoder_pipe.md
Name: posit_decoder_pipe

Overview:
- Pipelined posit decoder, the inverse of the posit field encoder.
- Accepts an N-bit posit word on a valid/ready stream and emits its unpacked fields: sign, regime k, exponent, right-aligned fraction with its bit count, and zero/NaR flags.
- Sits at the PPU operand input, ahead of the arithmetic core.
- Two register stages, throughput one word per cycle, full backpressure.

Parameters:
- N, 16: posit width in bits; legal range 4..32.
- ES, 1: exponent field width in bits; legal range 0..3. When ES=0 the exp port is 1 bit wide and is tied to 0.
- K_W, $clog2(N)+1: width of the signed regime value k. Derived; do not override.
- FL_W, $clog2(N): width of frac_len. Derived.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: posit word present.
- in_ready, output, 1: decoder accepts the word this cycle.
- posit, input, N: posit word.
- out_valid, output, 1: decoded fields valid.
- out_ready, input, 1: consumer accepts the fields.
- sign, output, 1: posit sign bit.
- k, output, K_W: regime value, two's complement.
- exp, output, max(ES,1): exponent field.
- frac, output, N: fraction bits, LSB-aligned, no hidden bit.
- frac_len, output, FL_W: number of valid fraction bits.
- is_zero, output, 1: input was 0.
- is_nar, output, 1: input was NaR (1 followed by zeros).

Behaviour:
- Reset (rst=1 at a clock edge):
  - Stage valids s1_valid and s2_valid clear; out_valid=0.
  - All output data registers go to 0.
  - in_ready=1 in the first cycle after reset.
  - A word in flight during reset is discarded; no partial output is produced.
- Handshake:
  - A transfer occurs when valid and ready are both 1 at a clock edge.
  - s1_adv = !s2_valid | out_ready.
  - in_ready = !s1_valid | s1_adv. in_ready is combinational from out_ready only; there is no path from in_valid.
  - Once out_valid=1, the output fields hold stable until accepted.
- Stage 1 (capture):
  - Register sign = posit[N-1].
  - Register mag = posit[N-1] ? -posit : posit, computed modulo 2^N.
  - Register is_zero = (posit==0) and is_nar = (posit=={1,0...}).
- Stage 2 (field extraction from mag[N-2:0]):
  - r0 = mag[N-2]. m = length of the run of bits equal to r0, scanning from bit N-2 downward, capped at N-1.
  - k = r0 ? m-1 : -m.
  - reg_len = min(m+1, N-1); the terminator bit is absent when the run reaches the LSB.
  - rem = N-1-reg_len.
  - exp = the next min(ES,rem) bits, MSB-aligned into the ES-bit field, zero-padded on the right.
  - frac_len = max(rem-ES, 0). frac = the low frac_len bits of mag, upper bits 0.
- Special values:
  - When is_zero or is_nar is set: k=0, exp=0, frac=0, frac_len=0.
  - sign=0 for zero; sign=1 for NaR.
- Latency: an accepted input appears on out_valid 2 cycles later when out_ready is held 1.
- Pipeline ordering:
  - With out_ready=0, the pipe holds 2 words and then drops in_ready.
  - Order is preserved. No word is lost or duplicated under any valid/ready pattern.
- Simultaneous accept and emit in the same cycle with a full pipe is legal; throughput stays 1 word per cycle.

Test Plan:
- After reset, in_ready=1 and out_valid=0. Send 0x4000 with out_ready=1 → 2 cycles later sign=0, k=0, exp=0, frac=0x000, frac_len=12.
- Send 0x5A00 → k=0, exp=1, frac=0xA00, frac_len=12. Send 0xC000 → sign=1, k=0, exp=0, frac=0, frac_len=12.
- Send 0x0000 → is_zero=1, all fields 0. Send 0x8000 → is_nar=1, sign=1, fields 0.
- Send 0x7FFF → k=14, exp=0, frac_len=0. Send 0x0001 → k=-14, exp=0, frac_len=0.
- Stream 8 back-to-back words with out_ready toggling at random → output sequence matches a reference model in order. in_ready drops exactly when 2 words are held.
- Assert rst while 2 words are in flight → next cycle out_valid=0 and in_ready=1; neither word is ever emitted.
